// File: rtl/board_controller.sv
// board_controller: connect-four game-state controller for a 6x7 board.
// Accepts column drops for the side to move, places the piece at the lowest
// free row, scans the four line directions (one per cycle) for a run of
// WIN_LEN, then ends the game on a win or full board, or passes the turn.
// Optional build macro: MOVE_TIMEOUT_EN (forfeit the turn after
// TIMEOUT_CYCLES idle cycles without a drop).
module board_controller #(
   parameter int WIN_LEN        = 4,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   new_game,
   input  logic                   drop_valid,
   input  logic [2:0]             drop_col,
   output logic                   drop_ready,
   output logic                   illegal,
   output logic [0:5][0:6][1:0]   tiles,
   output logic                   player,
   output logic                   win,
   output logic [1:0]             winner,
   output logic                   draw,
   output logic                   busy
);

   typedef logic [0:5][0:6][1:0] board_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLACE = 2'd1,
      CHECK = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [3:0] WIN_LEN_L = 4'(WIN_LEN);
   localparam logic [5:0] CELLS     = 6'd42;

   // Reject parameter values the board geometry cannot support
   if (WIN_LEN < 2 || WIN_LEN > 6) begin : g_bad_win_len
      $error("board_controller: WIN_LEN must be in 2..6");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("board_controller: TIMEOUT_CYCLES must be at least 2");
   end

   state_t           state_q, state_d;
   board_t           tiles_q, tiles_d;
   logic [0:6][2:0]  height_q, height_d;
   logic [5:0]       moves_q, moves_d;
   logic             player_q, player_d;
   logic             win_q, win_d;
   logic [1:0]       winner_q, winner_d;
   logic             draw_q, draw_d;
   logic             illegal_q, illegal_d;
   logic [2:0]       col_q, col_d;
   logic [2:0]       row_q, row_d;
   logic [1:0]       dir_q, dir_d;
   logic             hit_q, hit_d;

   logic [1:0]       mover_code;
   logic [3:0]       run_len_sel;
   logic             hit_any;

   // Out-of-board coordinates read as empty so runs stop at the edge
   function automatic logic [1:0] cell_at(input board_t b, input int r, input int c);
      logic [1:0] v;
      v = 2'b00;
      if (r >= 0 && r <= 5 && c >= 0 && c <= 6) begin
         v = b[r[2:0]][c[2:0]];
      end
      return v;
   endfunction

   assign mover_code = player_q ? 2'b10 : 2'b01;

   // Direction vectors: 0 horizontal, 1 vertical, 2 down-right, 3 up-right
   for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      localparam int DR = (gi == 0) ? 0 : ((gi == 3) ? -1 : 1);
      localparam int DC = (gi == 1) ? 0 : 1;
      logic [3:0] len_c;

      // Contiguous run of the mover's code through the placed cell, both senses
      always_comb begin
         logic going_fwd;
         logic going_bwd;
         len_c     = 4'd1;
         going_fwd = 1'b1;
         going_bwd = 1'b1;
         for (int k = 1; k < 7; k++) begin
            if (going_fwd &&
                cell_at(tiles_q, int'(row_q) + k * DR, int'(col_q) + k * DC) == mover_code) begin
               len_c = len_c + 4'd1;
            end else begin
               going_fwd = 1'b0;
            end
            if (going_bwd &&
                cell_at(tiles_q, int'(row_q) - k * DR, int'(col_q) - k * DC) == mover_code) begin
               len_c = len_c + 4'd1;
            end else begin
               going_bwd = 1'b0;
            end
         end
      end
   end

   // Pick the run length for the direction under test this cycle
   always_comb begin
      run_len_sel = 4'd0;
      case (dir_q)
         2'd0:    run_len_sel = g_dir[0].len_c;
         2'd1:    run_len_sel = g_dir[1].len_c;
         2'd2:    run_len_sel = g_dir[2].len_c;
         default: run_len_sel = g_dir[3].len_c;
      endcase
   end

   assign hit_any = hit_q | (run_len_sel >= WIN_LEN_L);

`ifdef MOVE_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          accept;

   // Any drop request seen in IDLE counts as activity, legal or not
   assign accept = (state_q == IDLE) && drop_valid;
`endif

   // Next-state, game rules and output values
   always_comb begin
      state_d   = state_q;
      tiles_d   = tiles_q;
      height_d  = height_q;
      moves_d   = moves_q;
      player_d  = player_q;
      win_d     = win_q;
      winner_d  = winner_q;
      draw_d    = draw_q;
      illegal_d = 1'b0;
      col_d     = col_q;
      row_d     = row_q;
      dir_d     = dir_q;
      hit_d     = hit_q;

      case (state_q)
         IDLE: begin
            if (drop_valid) begin
               if (drop_col > 3'd6) begin
                  illegal_d = 1'b1;
               end else if (height_q[drop_col] == 3'd6) begin
                  illegal_d = 1'b1;
               end else begin
                  col_d   = drop_col;
                  row_d   = 3'd5 - height_q[drop_col];
                  state_d = PLACE;
               end
            end
         end
         PLACE: begin
            tiles_d[row_q][col_q] = mover_code;
            height_d[col_q]       = height_q[col_q] + 3'd1;
            moves_d               = moves_q + 6'd1;
            hit_d                 = 1'b0;
            dir_d                 = 2'd0;
            state_d               = CHECK;
         end
         CHECK: begin
            if (dir_q == 2'd3) begin
               hit_d = 1'b0;
               if (hit_any) begin
                  win_d    = 1'b1;
                  winner_d = mover_code;
                  state_d  = OVER;
               end else if (moves_q == CELLS) begin
                  draw_d  = 1'b1;
                  state_d = OVER;
               end else begin
                  player_d = ~player_q;
                  state_d  = IDLE;
               end
            end else begin
               hit_d = hit_any;
               dir_d = dir_q + 2'd1;
            end
         end
         default: begin
            // OVER: frozen until new_game
            state_d = OVER;
         end
      endcase

`ifdef MOVE_TIMEOUT_EN
      idle_cnt_d = '0;
      if (state_q == IDLE && !accept) begin
         if (idle_cnt_q == IDLE_LAST) begin
            player_d = ~player_q;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
`endif

      // new_game wipes everything, including a move in flight
      if (new_game) begin
         state_d   = IDLE;
         tiles_d   = '0;
         height_d  = '0;
         moves_d   = '0;
         player_d  = 1'b0;
         win_d     = 1'b0;
         winner_d  = 2'b00;
         draw_d    = 1'b0;
         illegal_d = 1'b0;
         col_d     = 3'd0;
         row_d     = 3'd0;
         dir_d     = 2'd0;
         hit_d     = 1'b0;
`ifdef MOVE_TIMEOUT_EN
         idle_cnt_d = '0;
`endif
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tiles_q   <= '0;
         height_q  <= '0;
         moves_q   <= '0;
         player_q  <= 1'b0;
         win_q     <= 1'b0;
         winner_q  <= 2'b00;
         draw_q    <= 1'b0;
         illegal_q <= 1'b0;
         col_q     <= 3'd0;
         row_q     <= 3'd0;
         dir_q     <= 2'd0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tiles_q   <= tiles_d;
         height_q  <= height_d;
         moves_q   <= moves_d;
         player_q  <= player_d;
         win_q     <= win_d;
         winner_q  <= winner_d;
         draw_q    <= draw_d;
         illegal_q <= illegal_d;
         col_q     <= col_d;
         row_q     <= row_d;
         dir_q     <= dir_d;
         hit_q     <= hit_d;
      end
   end

`ifdef MOVE_TIMEOUT_EN
   // Idle-turn counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`endif

   assign drop_ready = (state_q == IDLE);
   assign busy       = (state_q == PLACE) || (state_q == CHECK);
   assign illegal    = illegal_q;
   assign tiles      = tiles_q;
   assign player     = player_q;
   assign win        = win_q;
   assign winner     = winner_q;
   assign draw       = draw_q;

endmodule

// File: tb/tb_board_controller.sv
// Testbench for board_controller: table of drop vectors with a scoreboard
// queue, plus hand-written sequences for new_game/reset/timeout corners.
module tb_board_controller;

   localparam int WIN_LEN        = 4;
   localparam int TIMEOUT_CYCLES = 10;

   localparam int C4A[8]  = '{6, 0, 5, 1, 4, 2, 0, 3};
   localparam int R4A[8]  = '{5, 5, 5, 5, 5, 5, 4, 5};
   localparam int C4B[11] = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
   localparam int C4C[11] = '{6, 5, 5, 4, 3, 4, 4, 3, 0, 3, 3};
   localparam int R4B[11] = '{5, 5, 4, 5, 5, 4, 3, 4, 5, 3, 2};

   logic                 clk;
   logic                 rst_n;
   logic                 new_game;
   logic                 drop_valid;
   logic [2:0]           drop_col;
   logic                 drop_ready;
   logic                 illegal;
   logic [0:5][0:6][1:0] tiles;
   logic                 player;
   logic                 win;
   logic [1:0]           winner;
   logic                 draw;
   logic                 busy;

   logic [0:5][0:6][1:0] model;

   typedef struct {
      bit         ng;
      int         col;
      bit         ill;
      int         row;
      logic [1:0] code;
      bit         p;
      bit         w;
      logic [1:0] wn;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   board_controller #(
      .WIN_LEN        (WIN_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .new_game   (new_game),
      .drop_valid (drop_valid),
      .drop_col   (drop_col),
      .drop_ready (drop_ready),
      .illegal    (illegal),
      .tiles      (tiles),
      .player     (player),
      .win        (win),
      .winner     (winner),
      .draw       (draw),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit ng, input int col, input bit ill, input int row,
                      input logic [1:0] code, input bit p, input bit w, input logic [1:0] wn);
      vec_t v;
      v.ng = ng; v.col = col; v.ill = ill; v.row = row;
      v.code = code; v.p = p; v.w = w; v.wn = wn;
      vecs.push_back(v);
   endtask

   // Legal drop number idx of a game red opened; won = this drop ends the game
   task automatic add_alt(input bit ng, input int idx, input int col, input int row, input bit won);
      logic [1:0] code;
      bit         mover;
      mover = (idx % 2) == 1;
      code  = mover ? 2'b10 : 2'b01;
      add(ng, col, 1'b0, row, code, won ? mover : ~mover, won, won ? code : 2'b00);
   endtask

   task automatic do_new_game();
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      model    = '0;
   endtask

   // Wait for busy to drop; returns negedges waited, bounded
   task automatic wait_not_busy(output int cyc);
      cyc = 0;
      while (busy && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      int   cyc;
      if (v.ng) do_new_game();
      exp_q.push_back(v);
      check("ready_before", drop_ready, 1'b1);
      drop_valid = 1'b1;
      drop_col   = 3'(v.col);
      @(negedge clk);                          // after acceptance edge N
      drop_valid = 1'b0;
      e = exp_q.pop_front();
      if (e.ill) begin
         check("illegal_pulse", illegal, 1'b1);
         check("illegal_busy", busy, 1'b0);
         @(negedge clk);
         check("illegal_one_cycle", illegal, 1'b0);
         check("illegal_board", tiles, model);
         check("illegal_player", player, e.p);
         $display("drop col=%0d rejected player=%0d", e.col, player);
      end else begin
         check("legal_no_illegal", illegal, 1'b0);
         check("busy_place", busy, 1'b1);
         @(negedge clk);                       // after N+1
         model[e.row][e.col] = e.code;
         check("board_after_place", tiles, model);
         check("busy_check", busy, 1'b1);
         wait_not_busy(cyc);
         check("busy_cycles", cyc + 1, 5);
         check("player_after", player, e.p);
         check("win_after", win, e.w);
         check("winner_after", winner, e.wn);
         check("draw_after", draw, 1'b0);
         check("ready_after", drop_ready, !e.w);
         $display("drop col=%0d row=%0d code=%0b player=%0d win=%0d winner=%0b",
                  e.col, e.row, tiles[e.row][e.col], player, win, winner);
         if (e.w) begin
            // Game over: further requests are ignored without an illegal pulse
            drop_valid = 1'b1;
            drop_col   = 3'd4;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("over_no_illegal", illegal, 1'b0);
               check("over_not_ready", drop_ready, 1'b0);
            end
            drop_valid = 1'b0;
            check("over_board", tiles, model);
            check("over_player", player, e.p);
            check("over_win", win, 1'b1);
         end
      end
   endtask

   initial begin
      int cyc;
      rst_n      = 1'b0;
      new_game   = 1'b0;
      drop_valid = 1'b0;
      drop_col   = 3'd0;
      model      = '0;

      // Single drop after reset
      add_alt(1'b0, 0, 3, 5, 1'b0);
      // Vertical red win in column 0
      add_alt(1'b1, 0, 0, 5, 1'b0);
      add_alt(1'b0, 1, 1, 5, 1'b0);
      add_alt(1'b0, 2, 0, 4, 1'b0);
      add_alt(1'b0, 3, 1, 4, 1'b0);
      add_alt(1'b0, 4, 0, 3, 1'b0);
      add_alt(1'b0, 5, 1, 3, 1'b0);
      add_alt(1'b0, 6, 0, 2, 1'b1);
      // Fill column 2, then a full-column and an out-of-range request
      for (int i = 0; i < 6; i++) add_alt(i == 0, i, 2, 5 - i, 1'b0);
      add(1'b0, 2, 1'b1, 0, 2'b00, 1'b0, 1'b0, 2'b00);
      add(1'b0, 7, 1'b1, 0, 2'b00, 1'b0, 1'b0, 2'b00);
      add_alt(1'b0, 6, 3, 5, 1'b0);
      // Yellow horizontal win, then up-right and down-right red diagonals
      for (int i = 0; i < 8; i++)  add_alt(i == 0, i, C4A[i], R4A[i], i == 7);
      for (int i = 0; i < 11; i++) add_alt(i == 0, i, C4B[i], R4B[i], i == 10);
      for (int i = 0; i < 11; i++) add_alt(i == 0, i, C4C[i], R4B[i], i == 10);

      repeat (2) @(negedge clk);
      check("rst_ready", drop_ready, 1'b1);
      check("rst_tiles", tiles, 84'd0);
      check("rst_player", player, 1'b0);
      check("rst_win", {win, winner, draw, illegal, busy}, 6'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) apply(vecs[i]);

      // new_game during CHECK aborts the move
      do_new_game();
      check("ng_tiles", tiles, 84'd0);
      check("ng_state", {win, winner, player, drop_ready}, 5'b00001);
      drop_valid = 1'b1;
      drop_col   = 3'd3;
      @(negedge clk);                          // after N
      drop_valid = 1'b0;
      @(negedge clk);                          // after N+1
      check("ng_placed", tiles[5][3], 2'b01);
      @(negedge clk);                          // after N+2
      new_game = 1'b1;
      @(negedge clk);                          // after N+3
      new_game = 1'b0;
      check("ng_mid_tiles", tiles, 84'd0);
      check("ng_mid_flags", {win, player, drop_ready, busy}, 4'b0010);
      repeat (3) @(negedge clk);
      check("ng_mid_stays", {tiles[5][3], player, busy}, 4'd0);
      $display("new_game in CHECK: ready=%0d player=%0d", drop_ready, player);

      // Asynchronous reset in the middle of PLACE
      drop_valid = 1'b1;
      drop_col   = 3'd0;
      @(negedge clk);
      drop_valid = 1'b0;
      wait_not_busy(cyc);
      check("pre_rst_player", player, 1'b1);
      drop_valid = 1'b1;
      drop_col   = 3'd1;
      @(negedge clk);                          // now in PLACE
      drop_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_tiles", tiles, 84'd0);
      check("async_player", player, 1'b0);
      check("async_ready", {drop_ready, busy}, 2'b10);
      $display("async reset mid-PLACE: player=%0d busy=%0d", player, busy);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef MOVE_TIMEOUT_EN
      repeat (9) @(negedge clk);
      check("to_not_yet", player, 1'b0);
      @(negedge clk);
      check("to_toggle", player, 1'b1);
      check("to_board", tiles, 84'd0);
      repeat (9) @(negedge clk);
      check("to_not_yet2", player, 1'b1);
      drop_valid = 1'b1;
      drop_col   = 3'd0;
      @(negedge clk);                          // acceptance on the expiry edge
      drop_valid = 1'b0;
      check("to_accept_wins", player, 1'b1);
      check("to_accept_busy", busy, 1'b1);
      wait_not_busy(cyc);
      check("to_move_done", {tiles[5][0], player}, 3'b100);
      $display("timeout: player=%0d tile=%0b", player, tiles[5][0]);
`else
      repeat (12) @(negedge clk);
      check("no_timeout", player, 1'b0);
      $display("idle 12 cycles: player=%0d", player);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
